// File: rtl/issue_scoreboard_pkg.sv
// Shared register-id type and write-class encodings used by decode and the issue scoreboard.
package issue_scoreboard_pkg;

    typedef logic [5:0] reg_id_t;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_GPR  = 2'b01;
    localparam logic [1:0] RW_FPR  = 2'b10;

    localparam int SB_ENTRIES = 64;

endpackage

// File: rtl/issue_scoreboard_sb_entry.sv
// One scoreboard entry: a countdown of cycles until the pending write lands.
// SB_FWD_BYPASS_EN: a count of 1 reports ready, because the forwarding network supplies the value.
module sb_entry #(
    parameter int WAIT_W = 5
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              load_en,
    input  logic [WAIT_W-1:0] load_val,
    output logic [WAIT_W-1:0] cnt,
    output logic              ready,
    output logic              busy
);

    // NOTE: sequential state uses non-blocking assignments so every entry samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load_en) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

`ifdef SB_FWD_BYPASS_EN
    assign ready = (cnt <= WAIT_W'(1));
`else
    assign ready = !busy;
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard between decode and execute: stalls decode on RAW/WAW hazards and counts stalls.
// Optional build macro SB_FWD_BYPASS_EN lets a consumer issue one cycle early via forwarding.
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int WAIT_W      = 5,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   id_valid,
    input  logic [5:0]             id_rs,
    input  logic                   id_rs_used,
    input  logic [5:0]             id_rt,
    input  logic                   id_rt_used,
    input  logic [1:0]             id_rw,
    input  logic [4:0]             id_rd,
    input  logic [WAIT_W-1:0]      id_wait,
    output logic                   stall,
    output logic                   issue,
    output logic                   busy_any,
    output logic [STALL_CNT_W-1:0] stall_count
);

    reg_id_t                 dst_id;
    logic                    dst_valid;
    logic                    rs_ready;
    logic                    rt_ready;
    logic                    waw_hazard;
    logic [WAIT_W-1:0]       cnt [SB_ENTRIES];
    logic [SB_ENTRIES-1:0]   ready_vec;
    logic [SB_ENTRIES-1:0]   busy_vec;

    assign dst_id    = {id_rw == RW_FPR, id_rd};
    assign dst_valid = ((id_rw == RW_GPR) || (id_rw == RW_FPR)) && (dst_id != '0) && (id_wait != '0);

    for (genvar g = 0; g < SB_ENTRIES; g++) begin : g_entry
        sb_entry #(.WAIT_W(WAIT_W)) u_entry (
            .clk      (clk),
            .rstn     (rstn),
            .load_en  (issue && dst_valid && (dst_id == reg_id_t'(g))),
            .load_val (id_wait),
            .cnt      (cnt[g]),
            .ready    (ready_vec[g]),
            .busy     (busy_vec[g])
        );
    end

    // GPR 0 is hardwired and never pending, so it is ready regardless of its entry.
    assign rs_ready   = (id_rs == '0) || ready_vec[id_rs];
    assign rt_ready   = (id_rt == '0) || ready_vec[id_rt];
    // A younger writer must not land before an older one to the same register.
    assign waw_hazard = dst_valid && (cnt[dst_id] > id_wait);

    assign stall    = id_valid && ((id_rs_used && !rs_ready) || (id_rt_used && !rt_ready) || waw_hazard);
    assign issue    = id_valid && !stall;
    assign busy_any = |busy_vec;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: reference model + expectation queue, vector table, hazard sequences.
module tb_issue_scoreboard;
    import issue_scoreboard_pkg::*;

`ifdef SB_FWD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        id_valid;
    logic [5:0]  id_rs;
    logic        id_rs_used;
    logic [5:0]  id_rt;
    logic        id_rt_used;
    logic [1:0]  id_rw;
    logic [4:0]  id_rd;
    logic [4:0]  id_wait;
    logic        stall, issue, busy_any;
    logic [31:0] stall_count;
    logic        stall_s, issue_s, busy_any_s;
    logic [3:0]  stall_count_s;

    issue_scoreboard #(.WAIT_W(5), .STALL_CNT_W(32)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rw(id_rw), .id_rd(id_rd), .id_wait(id_wait),
        .stall(stall), .issue(issue), .busy_any(busy_any), .stall_count(stall_count)
    );

    issue_scoreboard #(.WAIT_W(5), .STALL_CNT_W(4)) dut_sat (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rt(id_rt), .id_rt_used(id_rt_used), .id_rw(id_rw), .id_rd(id_rd), .id_wait(id_wait),
        .stall(stall_s), .issue(issue_s), .busy_any(busy_any_s), .stall_count(stall_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [5:0] rs;
        logic       rs_used;
        logic [5:0] rt;
        logic       rt_used;
        logic [1:0] rw;
        logic [4:0] rd;
        logic [4:0] wt;
        logic       exp_stall;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        logic stall;
        logic issue;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_cnt[64];
    int   m_sc;
    int   m_sc4;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic [5:0] rs, input logic rs_used,
                                input logic [5:0] rt, input logic rt_used, input logic [1:0] rw,
                                input logic [4:0] rd, input logic [4:0] wt);
        vec_t v;
        v.valid = valid; v.rs = rs; v.rs_used = rs_used; v.rt = rt; v.rt_used = rt_used;
        v.rw = rw; v.rd = rd; v.wt = wt; v.exp_stall = 1'bx; v.exp_busy = 1'bx;
        return v;
    endfunction

    function automatic vec_t mkx(input vec_t b, input logic es, input logic eb);
        vec_t v;
        v = b; v.exp_stall = es; v.exp_busy = eb;
        return v;
    endfunction

    function automatic bit m_ready(input logic [5:0] e);
        if (e == 6'd0) return 1'b1;
        return BYP ? (m_cnt[e] <= 1) : (m_cnt[e] == 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 0;
        m_sc  = 0;
        m_sc4 = 0;
    endtask

    // One decode cycle: drive, compare combinational outputs mid-cycle, advance model, compare counters.
    task automatic step(input vec_t v, output logic got_stall);
        exp_t       e;
        logic [5:0] d;
        bit         dv;
        bit         any;
        id_valid = v.valid; id_rs = v.rs; id_rs_used = v.rs_used; id_rt = v.rt;
        id_rt_used = v.rt_used; id_rw = v.rw; id_rd = v.rd; id_wait = v.wt;
        d  = {v.rw == RW_FPR, v.rd};
        dv = ((v.rw == RW_GPR) || (v.rw == RW_FPR)) && (d != 6'd0) && (v.wt != 5'd0);
        any = 1'b0;
        for (int i = 0; i < 64; i++) if (m_cnt[i] != 0) any = 1'b1;
        e.stall = v.valid && ((v.rs_used && !m_ready(v.rs)) || (v.rt_used && !m_ready(v.rt))
                              || (dv && (m_cnt[d] > int'(v.wt))));
        e.issue = v.valid && !e.stall;
        e.busy  = any;
        exp_q.push_back(e);
        #3;
        e = exp_q.pop_front();
        check("stall", stall, e.stall);
        check("issue", issue, e.issue);
        check("busy_any", busy_any, e.busy);
        check("stall_w4", stall_s, e.stall);
        got_stall = stall;
        @(posedge clk);
        for (int i = 0; i < 64; i++) if (m_cnt[i] > 0) m_cnt[i]--;
        if (e.issue && dv) m_cnt[d] = int'(v.wt);
        if (e.stall) begin
            m_sc++;
            if (m_sc4 < 15) m_sc4++;
        end
        #1;
        check("stall_count", stall_count, 64'(m_sc));
        check("stall_count_w4", stall_count_s, 64'(m_sc4));
    endtask

    // Hold one instruction in decode until it issues; bounded so a stuck stall cannot hang the run.
    task automatic hold(input string name, input vec_t v, output int stalls);
        logic s;
        bit   done;
        stalls = 0;
        done   = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            step(v, s);
            if (s) stalls++;
            else done = 1'b1;
        end
        if (!done) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        id_valid = 1'b0; id_rs = '0; id_rs_used = 1'b0; id_rt = '0; id_rt_used = 1'b0;
        id_rw = RW_NONE; id_rd = '0; id_wait = '0;
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    vec_t idle;
    vec_t tbl[12];
    logic s;
    int   n;

    initial begin
        idle = mk(0, 0, 0, 0, 0, RW_NONE, 0, 0);
        do_reset();
        check("reset_stall_count", stall_count, 64'd0);
        check("reset_busy_any", busy_any, 64'd0);

        // RAW on GPR 5
        step(mk(1, 0, 0, 0, 0, RW_GPR, 5, 3), s);
        hold("raw_gpr", mk(1, 6'd5, 1, 0, 0, RW_NONE, 0, 0), n);
        check("raw_gpr_stalls", 64'(n), BYP ? 64'd2 : 64'd3);

        // Asynchronous reset with GPR 5 pending and a dependent reader in decode
        step(mk(1, 0, 0, 0, 0, RW_GPR, 5, 3), s);
        id_valid = 1'b1; id_rs = 6'd5; id_rs_used = 1'b1; id_rw = RW_NONE; id_wait = '0;
        #1;
        check("pre_reset_stall", stall, 64'd1);
        check("pre_reset_stall_count", stall_count, 64'(m_sc));
        #1 rstn = 1'b0;
        #1;
        check("async_reset_stall", stall, 64'd0);
        check("async_reset_issue", issue, 64'd1);
        check("async_reset_busy", busy_any, 64'd0);
        check("async_reset_count", stall_count, 64'd0);
        model_reset();
        @(posedge clk);
        #1 rstn = 1'b1;

        // GPR/FPR separation: FPR 7 pending must not block GPR 7
        step(mk(1, 0, 0, 0, 0, RW_FPR, 7, 6), s);
        step(mk(1, 6'd7, 1, 0, 0, RW_NONE, 0, 0), s);
        check("gpr7_no_stall", s, 64'd0);
        for (int i = 0; i < 8; i++) step(idle, s);
        step(mk(1, 0, 0, 0, 0, RW_FPR, 7, 6), s);
        hold("fpr39", mk(1, 6'd39, 1, 0, 0, RW_NONE, 0, 0), n);
        check("fpr39_stalls", 64'(n), BYP ? 64'd5 : 64'd6);

        // Writes to GPR 0 are discarded
        step(idle, s);
        step(mk(1, 0, 0, 0, 0, RW_GPR, 0, 3), s);
        check("zero_reg_busy", busy_any, 64'd0);
        step(mk(1, 6'd0, 1, 6'd0, 1, RW_NONE, 0, 0), s);
        check("zero_reg_reader", s, 64'd0);

        // WAW ordering on FPR 2 (entry 34)
        step(mk(1, 0, 0, 0, 0, RW_FPR, 2, 6), s);
        hold("waw", mk(1, 0, 0, 0, 0, RW_FPR, 2, 1), n);
        check("waw_stalls", 64'(n), 64'd5);
        check("waw_mark_busy", busy_any, 64'd1);
        step(mk(1, 6'd34, 1, 0, 0, RW_NONE, 0, 0), s);
        check("waw_mark_reader", s, BYP ? 64'd0 : 64'd1);

        // Vector table from a clean state; rows chosen so expectations hold in both builds
        do_reset();
        tbl[0]  = mkx(mk(1, 0,     0, 0,      0, RW_GPR,  3, 2), 0, 0);
        tbl[1]  = mkx(mk(1, 6'd3,  1, 0,      0, RW_NONE, 0, 0), 1, 1);
        tbl[2]  = mkx(mk(1, 6'd3,  0, 0,      0, RW_FPR,  3, 4), 0, 1);
        tbl[3]  = mkx(mk(1, 0,     0, 6'd35,  1, RW_NONE, 0, 0), 1, 1);
        tbl[4]  = mkx(mk(0, 0,     0, 6'd35,  1, RW_NONE, 0, 0), 0, 1);
        tbl[5]  = mkx(mk(1, 6'd3,  1, 0,      0, RW_FPR,  3, 1), 1, 1);
        tbl[6]  = mkx(mk(1, 6'd3,  1, 0,      0, RW_FPR,  3, 1), 0, 1);
        tbl[7]  = mkx(mk(1, 6'd0,  1, 0,      0, RW_GPR,  0, 7), 0, 1);
        tbl[8]  = mkx(mk(1, 0,     0, 0,      0, RW_NONE, 0, 0), 0, 0);
        tbl[9]  = mkx(mk(1, 0,     0, 0,      0, 2'b11,   4, 5), 0, 0);
        tbl[10] = mkx(mk(1, 6'd4,  1, 0,      0, RW_GPR,  4, 0), 0, 0);
        tbl[11] = mkx(mk(1, 6'd4,  1, 6'd4,   1, RW_NONE, 0, 0), 0, 0);
        for (int r = 0; r < 12; r++) begin
            id_valid = tbl[r].valid; id_rs = tbl[r].rs; id_rs_used = tbl[r].rs_used;
            id_rt = tbl[r].rt; id_rt_used = tbl[r].rt_used; id_rw = tbl[r].rw;
            id_rd = tbl[r].rd; id_wait = tbl[r].wt;
            #2;
            check($sformatf("tbl%0d_stall", r), stall, tbl[r].exp_stall);
            check($sformatf("tbl%0d_busy", r), busy_any, tbl[r].exp_busy);
            step(tbl[r], s);
        end

        // Stall counter saturation on the 4-bit instance
        do_reset();
        step(mk(1, 0, 0, 0, 0, RW_GPR, 9, 20), s);
        hold("sat", mk(1, 6'd9, 1, 0, 0, RW_NONE, 0, 0), n);
        check("sat_stalls", 64'(n), BYP ? 64'd19 : 64'd20);
        check("sat_count_w4", stall_count_s, 64'hF);
        check("sat_count_w32", stall_count, BYP ? 64'd19 : 64'd20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
